// File: rtl/ssp_pkg.sv
// ============================================================================
// Module      : ssp_pkg
// Description : Shared sizes and types for the single-stage processor
//               write-back path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ssp_pkg;

    localparam int NUM_REGS = 16;
    localparam int SEL_W    = 4;
    localparam int ERRCNT_W = 8;
    localparam logic [ERRCNT_W-1:0] ERRCNT_MAX = 8'd255;

    typedef logic [SEL_W-1:0] reg_idx_t;

endpackage

`default_nettype wire

// File: rtl/onehot16_encoder.sv
// ============================================================================
// Module      : onehot16_encoder
// Description : Combinational 16-to-4 one-hot encoder with an exactly-one-set
//               validity flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot16_encoder
    import ssp_pkg::*;
(
    input  logic [NUM_REGS-1:0] onehot,
    output reg_idx_t            idx,
    output logic                valid
);

    logic [SEL_W:0] w_count;
    reg_idx_t       w_idx;

    // The index only matters when exactly one bit is set; otherwise it is
    // the highest set bit and is ignored downstream.
    always_comb begin
        w_idx   = '0;
        w_count = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (onehot[i]) begin
                w_idx   = reg_idx_t'(i);
                w_count = w_count + (SEL_W+1)'(1);
            end
        end
    end

    assign idx   = w_idx;
    assign valid = (w_count == (SEL_W+1)'(1));

endmodule

`default_nettype wire

// File: rtl/reg_file16_wb.sv
// ============================================================================
// Module      : reg_file16_wb
// Description : 16-entry write-back register file with a one-cycle write
//               staging register, two combinational read ports and malformed
//               write-select detection. Optional macro REGFILE_BYPASS_EN
//               forwards the staged write to the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module reg_file16_wb
    import ssp_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int R0_ZERO = 0
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [NUM_REGS-1:0] wr_onehot,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic [SEL_W-1:0]    rd_sel_a,
    input  logic [SEL_W-1:0]    rd_sel_b,
    output logic [DATA_W-1:0]   rd_data_a,
    output logic [DATA_W-1:0]   rd_data_b,
    output logic                onehot_err,
    output logic [ERRCNT_W-1:0] err_count
);

    localparam logic c_r0_zero = (R0_ZERO != 0);

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic                r_pend_valid;
    reg_idx_t            r_pend_idx;
    logic [DATA_W-1:0]   r_pend_data;
    logic                r_onehot_err;
    logic [ERRCNT_W-1:0] r_err_count;

    reg_idx_t            w_enc_idx;
    logic                w_enc_valid;
    logic                w_bad_req;

    onehot16_encoder u_enc (
        .onehot (wr_onehot),
        .idx    (w_enc_idx),
        .valid  (w_enc_valid)
    );

    assign w_bad_req = wr_en && !w_enc_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_idx   <= '0;
            r_pend_data  <= '0;
            r_onehot_err <= 1'b0;
            r_err_count  <= '0;
        end else begin
            r_pend_valid <= wr_en && w_enc_valid;
            if (wr_en && w_enc_valid) begin
                r_pend_idx  <= w_enc_idx;
                r_pend_data <= wr_data;
            end
            r_onehot_err <= w_bad_req;
            if (w_bad_req && (r_err_count != ERRCNT_MAX)) begin
                r_err_count <= r_err_count + ERRCNT_W'(1);
            end
        end
    end

    // Commit of the staged write shares the edge with staging of the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_pend_valid && !(c_r0_zero && (r_pend_idx == '0))) begin
            r_regs[r_pend_idx] <= r_pend_data;
        end
    end

    logic [SEL_W-1:0]  w_sel  [2];
    logic [DATA_W-1:0] w_rd   [2];

    assign w_sel[0] = rd_sel_a;
    assign w_sel[1] = rd_sel_b;

    generate
        for (genvar p = 0; p < 2; p++) begin : g_rd_port
            always_comb begin
                w_rd[p] = r_regs[w_sel[p]];
`ifdef REGFILE_BYPASS_EN
                if (r_pend_valid && (r_pend_idx == w_sel[p])) begin
                    w_rd[p] = r_pend_data;
                end
`endif
                if (c_r0_zero && (w_sel[p] == '0)) begin
                    w_rd[p] = '0;
                end
            end
        end
    endgenerate

    assign rd_data_a  = w_rd[0];
    assign rd_data_b  = w_rd[1];
    assign onehot_err = r_onehot_err;
    assign err_count  = r_err_count;

endmodule

`default_nettype wire

// File: doc/reg_file16_wb.md
Name: reg_file16_wb

Overview:
- Write-back register file of the single-stage processor; sits directly downstream of the 4-to-16 destination decoder.
- Consumes the decoder's one-hot write-select, stages each write for one cycle, then commits it into one of 16 registers.
- Provides two combinational read ports and flags malformed (non-one-hot) write selects.

Parameters:
- DATA_W, 16, register and data-path width in bits
- R0_ZERO, 0, when 1 register 0 reads as zero and ignores writes

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst_n  input  1  asynchronous, active-low reset
- wr_en  input  1  write request for this cycle
- wr_onehot  input  16  one-hot destination select from the decoder; bit i selects register i
- wr_data  input  DATA_W  data to write
- rd_sel_a  input  4  read port A register index
- rd_sel_b  input  4  read port B register index
- rd_data_a  output  DATA_W  port A read data, combinational
- rd_data_b  output  DATA_W  port B read data, combinational
- onehot_err  output  1  one-cycle pulse, registered: previous cycle had wr_en=1 with wr_onehot not exactly one-hot
- err_count  output  8  saturating count of malformed write requests

Behaviour:
- Reset (rst_n=0, asynchronous): all 16 registers 0, pend_valid 0, pend_idx 0, pend_data 0, onehot_err 0, err_count 0. rd_data_a/b therefore read 0.
- Reset asserted mid-operation discards any staged write; no commit occurs after release.
- Stage 1 (edge N): if wr_en=1 and wr_onehot has exactly one bit set:
  - pend_valid<=1
  - pend_idx<=encoded index
  - pend_data<=wr_data
  - Otherwise pend_valid<=0.
- Stage 2 (edge N+1): if pend_valid=1, regs[pend_idx]<=pend_data.
- Without bypass, a write is visible on the read ports after edge N+1, i.e. 2-cycle write-to-read latency.
- Back-to-back writes: commit of write k and staging of write k+1 occur on the same edge with no conflict. Throughput is one write per cycle.
- Same register written on consecutive cycles: the later write is committed last and wins.
- Malformed select (wr_en=1 and popcount(wr_onehot)!=1, including all-zero):
  - write dropped
  - onehot_err=1 for exactly the following cycle
  - err_count increments, saturating at 255
- wr_en=0: wr_onehot ignored, no error regardless of value.
- R0_ZERO=1: reads of index 0 return 0. A staged write to index 0 is accepted and not flagged, but the commit has no effect.
- Reads are purely combinational from the array (plus bypass, below). rd_sel_a and rd_sel_b may be equal.

Optional Feature:
- Macro: REGFILE_BYPASS_EN
- Defined:
  - each read port returns pend_data when pend_valid=1 and rd_sel equals pend_idx (and not index 0 under R0_ZERO=1)
  - write-to-read latency becomes 1 cycle
  - pending data takes priority over array contents
- Undefined: no forwarding; read ports show array contents only (2-cycle latency).

Decomposition:
- Shared package ssp_pkg:
  - NUM_REGS=16
  - SEL_W=4
  - ERRCNT_W=8
  - ERRCNT_MAX=255
  - typedef for the 4-bit register index
- Sub-module onehot16_encoder (combinational):
  - input: 16-bit one-hot vector
  - outputs: 4-bit index and valid (exactly-one-set)
  - instantiated once on the write path

Test Plan:
- Reset check: hold rst_n=0 with random inputs -> all reads 0, onehot_err=0, err_count=0. Assert rst_n low while pend_valid=1 (wr_onehot=16'h0008, wr_data=16'hBEEF) -> after release, reg 3 reads 0.
- Basic write, bypass undefined: wr_en=1, wr_onehot=16'h0020, wr_data=16'h1234 at edge N; rd_sel_a=5 -> reads 0 after edge N, 16'h1234 after edge N+1.
- Bypass defined: same stimulus -> rd_data_a=16'h1234 immediately after edge N.
- Back-to-back same register: 16'h0004/16'hAAAA then 16'h0004/16'h5555 on consecutive cycles -> reg 2 finally 16'h5555. With bypass, a read between the commits returns 16'h5555 once the second write is staged.
- Malformed selects: wr_en=1 with wr_onehot=16'h0000, then 16'h0003 -> no register changes, onehot_err pulses twice, err_count=2. Drive 300 malformed requests -> err_count saturates at 255.
- R0_ZERO=1: write 16'hFFFF with wr_onehot=16'h0001 -> rd_data for index 0 stays 0, onehot_err stays 0. Simultaneously rd_sel_a=rd_sel_b=7 after writing 16'h0707 to reg 7 -> both ports read 16'h0707.
